// File: rtl/decode_issue_block.sv
// -----------------------------------------------------------------------------
// decode_issue_block
//
// Decode and issue stage of a small 8-bit pipeline. It decodes a 16-bit
// instruction word, reads operands from an 8x8 register file (with bypass
// from the writeback slot), detects a distance-1 read-after-write hazard
// against the instruction in EX, and inserts exactly one NOP bubble when one
// is found. Results come back on ans_ex and are written into the register
// file from the WB slot.
//
// Ports
//   clk          in   1  rising-edge clock for all state
//   reset        in   1  synchronous active-high reset
//   instr        in  16  [15:11] opcode, [10:8] rd, [7:5] rs, [7:0] imm8
//   instr_valid  in   1  instr holds a valid instruction
//   instr_ready  out  1  instr consumed on an edge with valid & ready
//   io_in        in   8  external input-port value
//   ans_ex       in   8  registered execution result (writeback data)
//   op_dec       out  5  registered opcode to execute
//   A            out  8  registered operand A  (R[rd])
//   B            out  8  registered operand B  (imm8 or R[rs])
//   data_in      out  8  registered io_in sample
//   stall_cnt    out  8  saturating count of hazard bubbles
// -----------------------------------------------------------------------------
module decode_issue_block (
    input  logic        clk,
    input  logic        reset,
    input  logic [15:0] instr,
    input  logic        instr_valid,
    output logic        instr_ready,
    input  logic [7:0]  io_in,
    input  logic [7:0]  ans_ex,
    output logic [4:0]  op_dec,
    output logic [7:0]  A,
    output logic [7:0]  B,
    output logic [7:0]  data_in,
    output logic [7:0]  stall_cnt
);

    typedef enum logic {
        RUN   = 1'b0,
        STALL = 1'b1
    } state_t;

    localparam logic [4:0] OP_NOP = 5'b11100;

    // Field extraction
    logic [4:0] opcode;
    logic [2:0] rd;
    logic [2:0] rs;
    logic [7:0] imm8;

    assign opcode = instr[15:11];
    assign rd     = instr[10:8];
    assign rs     = instr[7:5];
    assign imm8   = instr[7:0];

    // State
    state_t     state_q;
    logic [4:0] op_dec_q;
    logic [7:0] a_q;
    logic [7:0] b_q;
    logic [7:0] data_in_q;
    logic [7:0] stall_cnt_q;
    logic [2:0] ex_rd_q;
    logic       ex_wen_q;
    logic [2:0] wb_rd_q;
    logic       wb_wen_q;
    logic [7:0] rf_q [8];

    // Decode
    logic       wen_dec;
    logic       b_is_imm;
    logic [7:0] rd_val;
    logic [7:0] rs_val;
    logic       hazard;
    logic       issue;
    logic [7:0] stall_cnt_d;
    logic [7:0] rf_we;

    always_comb begin
        wen_dec = 1'b0;
        case (opcode) inside
            [5'd0:5'd2], [5'd4:5'd7], [5'd8:5'd10],
            [5'd12:5'd15], [5'd20:5'd22], [5'd25:5'd27]: wen_dec = 1'b1;
            default:                                     wen_dec = 1'b0;
        endcase
    end

    assign b_is_imm = (opcode[4:3] == 2'b01);

    // Bypass: the value being written this cycle is the one to read.
    assign rd_val = (wb_wen_q && (wb_rd_q == rd)) ? ans_ex : rf_q[rd];
    assign rs_val = (wb_wen_q && (wb_rd_q == rs)) ? ans_ex : rf_q[rs];

    // EX result is not available yet, so any dependency on it must wait one
    // cycle; after the bubble the producer sits in WB and the bypass covers it.
    // Checking EX before WB also guarantees the newer value wins when both
    // slots target the same register.
    assign hazard = ex_wen_q &&
                    ((ex_rd_q == rd) || (!b_is_imm && (ex_rd_q == rs)));

    assign issue       = instr_valid && ((state_q == STALL) || !hazard);
    assign instr_ready = !reset &&
                         ((state_q == STALL) || !(instr_valid && hazard));

    assign stall_cnt_d = (stall_cnt_q == 8'hFF) ? 8'hFF : stall_cnt_q + 8'd1;

    // Per-register write enables from the WB slot
    genvar gi;
    generate
        for (gi = 0; gi < 8; gi++) begin : g_rf_we
            assign rf_we[gi] = wb_wen_q && (wb_rd_q == 3'(gi));
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < 8; i++) begin
                rf_q[i] <= 8'h00;
            end
        end else begin
            for (int i = 0; i < 8; i++) begin
                if (rf_we[i]) begin
                    rf_q[i] <= ans_ex;
                end
            end
        end
    end

    // Issue FSM with registered outputs
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= RUN;
            op_dec_q    <= OP_NOP;
            a_q         <= 8'h00;
            b_q         <= 8'h00;
            data_in_q   <= 8'h00;
            stall_cnt_q <= 8'h00;
            ex_rd_q     <= 3'd0;
            ex_wen_q    <= 1'b0;
            wb_rd_q     <= 3'd0;
            wb_wen_q    <= 1'b0;
        end else begin
            wb_rd_q  <= ex_rd_q;
            wb_wen_q <= ex_wen_q;

            if (issue) begin
                op_dec_q  <= opcode;
                a_q       <= rd_val;
                b_q       <= b_is_imm ? imm8 : rs_val;
                data_in_q <= io_in;
                ex_rd_q   <= rd;
                ex_wen_q  <= wen_dec;
            end else begin
                op_dec_q  <= OP_NOP;
                a_q       <= 8'h00;
                b_q       <= 8'h00;
                ex_rd_q   <= 3'd0;
                ex_wen_q  <= 1'b0;
            end

            case (state_q)
                RUN: begin
                    if (instr_valid && hazard) begin
                        state_q     <= STALL;
                        stall_cnt_q <= stall_cnt_d;
                    end
                end
                STALL: begin
                    state_q <= RUN;
                end
                default: begin
                    state_q <= RUN;
                end
            endcase
        end
    end

    assign op_dec    = op_dec_q;
    assign A         = a_q;
    assign B         = b_q;
    assign data_in   = data_in_q;
    assign stall_cnt = stall_cnt_q;

endmodule

// File: tb/tb_decode_issue_block.sv
// -----------------------------------------------------------------------------
// tb_decode_issue_block
//
// Directed bench for decode_issue_block: reset state, independent issue,
// distance-1 and distance-2 RAW, non-writing producer, reset during a stall
// and stall counter saturation. Inputs change and outputs are sampled 1 ns
// after the rising edge.
// -----------------------------------------------------------------------------
module tb_decode_issue_block;

    logic        clk;
    logic        reset;
    logic [15:0] instr;
    logic        instr_valid;
    logic        instr_ready;
    logic [7:0]  io_in;
    logic [7:0]  ans_ex;
    logic [4:0]  op_dec;
    logic [7:0]  A;
    logic [7:0]  B;
    logic [7:0]  data_in;
    logic [7:0]  stall_cnt;

    int n_vec;
    int n_err;

    decode_issue_block dut (
        .clk         (clk),
        .reset       (reset),
        .instr       (instr),
        .instr_valid (instr_valid),
        .instr_ready (instr_ready),
        .io_in       (io_in),
        .ans_ex      (ans_ex),
        .op_dec      (op_dec),
        .A           (A),
        .B           (B),
        .data_in     (data_in),
        .stall_cnt   (stall_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
        $display("vec %0d %s observed=%h expected=%h", n_vec, tag, obs, exp);
    endtask

    task automatic do_reset();
        reset       = 1'b1;
        instr_valid = 1'b0;
        instr       = 16'h0000;
        ans_ex      = 8'h00;
        io_in       = 8'h00;
        tick();
        tick();
        reset = 1'b0;
        #1;
    endtask

    initial begin
        n_vec = 0;
        n_err = 0;

        // Reset state
        reset       = 1'b1;
        instr_valid = 1'b1;
        instr       = 16'h4105;
        ans_ex      = 8'h5A;
        io_in       = 8'h77;
        tick();
        tick();
        check("rst_op",    {3'b0, op_dec}, 8'h1C);
        check("rst_A",     A,              8'h00);
        check("rst_B",     B,              8'h00);
        check("rst_din",   data_in,        8'h00);
        check("rst_ready", {7'b0, instr_ready}, 8'h00);
        check("rst_scnt",  stall_cnt,      8'h00);
        reset       = 1'b0;
        instr_valid = 1'b0;
        #1;
        check("rst_ready_after", {7'b0, instr_ready}, 8'h01);

        // Independent pair: ADDI R1,#05 ; ADDI R2,#03
        do_reset();
        instr = 16'h4105; instr_valid = 1'b1; io_in = 8'h3C;
        #1;
        check("ind_ready1", {7'b0, instr_ready}, 8'h01);
        tick();
        check("ind_op1",  {3'b0, op_dec}, 8'h08);
        check("ind_A1",   A,       8'h00);
        check("ind_B1",   B,       8'h05);
        check("ind_din1", data_in, 8'h3C);
        instr = 16'h4203; io_in = 8'hC3;
        #1;
        check("ind_ready2", {7'b0, instr_ready}, 8'h01);
        tick();
        check("ind_op2",  {3'b0, op_dec}, 8'h08);
        check("ind_A2",   A,       8'h00);
        check("ind_B2",   B,       8'h03);
        check("ind_din2", data_in, 8'hC3);
        check("ind_scnt", stall_cnt, 8'h00);
        instr_valid = 1'b0;

        // RAW distance 1: ADDI R1,#05 ; ADD R2,R1
        do_reset();
        instr = 16'h4105; instr_valid = 1'b1;
        tick();
        check("raw1_op0", {3'b0, op_dec}, 8'h08);
        instr = 16'h0220;
        #1;
        check("raw1_ready_haz", {7'b0, instr_ready}, 8'h00);
        tick();
        check("raw1_bub_op", {3'b0, op_dec}, 8'h1C);
        check("raw1_bub_A",  A, 8'h00);
        check("raw1_bub_B",  B, 8'h00);
        check("raw1_scnt",   stall_cnt, 8'h01);
        ans_ex = 8'h05;
        #1;
        check("raw1_ready_stall", {7'b0, instr_ready}, 8'h01);
        tick();
        check("raw1_op", {3'b0, op_dec}, 8'h00);
        check("raw1_A",  A, 8'h00);
        check("raw1_B",  B, 8'h05);
        check("raw1_scnt2", stall_cnt, 8'h01);
        instr_valid = 1'b0;

        // RAW distance 2: ADDI R3,#07 ; idle ; ADD R4,R3 ; idle ; ADD R5,R3
        do_reset();
        instr = 16'h4307; instr_valid = 1'b1;
        tick();
        check("raw2_B0", B, 8'h07);
        instr_valid = 1'b0;
        tick();
        check("raw2_idle_op", {3'b0, op_dec}, 8'h1C);
        instr = 16'h0460; instr_valid = 1'b1; ans_ex = 8'h07;
        #1;
        check("raw2_ready", {7'b0, instr_ready}, 8'h01);
        tick();
        check("raw2_op",  {3'b0, op_dec}, 8'h00);
        check("raw2_A",   A, 8'h00);
        check("raw2_B",   B, 8'h07);
        check("raw2_scnt", stall_cnt, 8'h00);
        instr_valid = 1'b0; ans_ex = 8'h00;
        tick();
        ans_ex = 8'hAA;
        instr = 16'h0560; instr_valid = 1'b1;
        #1;
        check("raw2_ready2", {7'b0, instr_ready}, 8'h01);
        tick();
        check("raw2_R3_B", B, 8'h07);
        check("raw2_R5_A", A, 8'h00);
        instr_valid = 1'b0;

        // Non-writing producer: 10111 rd=1 ; ADD R2,R1
        do_reset();
        instr = 16'hB900; instr_valid = 1'b1;
        tick();
        check("nw_op0", {3'b0, op_dec}, 8'h17);
        instr = 16'h0220;
        #1;
        check("nw_ready", {7'b0, instr_ready}, 8'h01);
        tick();
        check("nw_op",   {3'b0, op_dec}, 8'h00);
        check("nw_scnt", stall_cnt, 8'h00);
        instr_valid = 1'b0;

        // Reset during the stall cycle
        do_reset();
        instr = 16'h4105; instr_valid = 1'b1;
        tick();
        instr = 16'h0220;
        tick();
        check("rms_bub_op", {3'b0, op_dec}, 8'h1C);
        reset = 1'b1; ans_ex = 8'h05;
        tick();
        check("rms_op",   {3'b0, op_dec}, 8'h1C);
        check("rms_B",    B, 8'h00);
        check("rms_scnt", stall_cnt, 8'h00);
        reset = 1'b0; instr_valid = 1'b0; ans_ex = 8'h55;
        tick();
        check("rms_idle_op", {3'b0, op_dec}, 8'h1C);
        instr = 16'h0220; instr_valid = 1'b1;
        #1;
        check("rms_ready", {7'b0, instr_ready}, 8'h01);
        tick();
        check("rms_op2", {3'b0, op_dec}, 8'h00);
        check("rms_R1",  B, 8'h00);
        instr_valid = 1'b0;

        // Stall counter saturation
        do_reset();
        for (int i = 0; i < 260; i++) begin
            instr = 16'h4105; instr_valid = 1'b1;
            tick();
            instr = 16'h0220;
            tick();
            tick();
            if (i == 2) begin
                check("sat_cnt3", stall_cnt, 8'h03);
            end
        end
        check("sat_cntFF", stall_cnt, 8'hFF);
        instr_valid = 1'b0;

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/decode_issue_block.md
DECODE_ISSUE_BLOCK -- requirements
Module: decode_issue_block

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-high reset; the clock is clk and the reset is reset.
REQ-002 The port clk SHALL be: clk  input  1  rising-edge clock for all state.
REQ-003 The port reset SHALL be: reset  input  1  synchronous active-high reset.
REQ-004 The port instr SHALL be: instr  input  16  instruction word, [15:11] opcode, [10:8] rd, [7:5] rs, [7:0] imm8.
REQ-005 The port instr_valid SHALL be: instr_valid  input  1  instr holds a valid instruction.
REQ-006 The port instr_ready SHALL be: instr_ready  output  1  instr is consumed on an edge where instr_valid and instr_ready are both 1.
REQ-007 The port io_in SHALL be: io_in  input  8  external input-port value.
REQ-008 The port ans_ex SHALL be: ans_ex  input  8  registered execution result, fed back for writeback.
REQ-009 The port op_dec SHALL be: op_dec  output  5  registered opcode to the execution stage.
REQ-010 The port A SHALL be: A  output  8  registered operand A.
REQ-011 The port B SHALL be: B  output  8  registered operand B.
REQ-012 The port data_in SHALL be: data_in  output  8  registered io_in sample.
REQ-013 The port stall_cnt SHALL be: stall_cnt  output  8  saturating count of hazard bubbles.

Function
REQ-014 The block SHALL hold an 8x8-bit register file R0-R7 whose reads are combinational.
REQ-015 On a handshake edge, the block SHALL register op_dec=instr[15:11], A=R[rd], and data_in=io_in.
REQ-016 On a handshake edge, B SHALL be registered as imm8 when opcode[4:3]=01, and as R[rs] otherwise.
REQ-017 The opcode SHALL set the write-enable wen only for opcodes 00000-00010, 00100-00111, 01000-01010, 01100-01111, 10100-10110, and 11001-11011; all other opcodes SHALL set wen=0.
REQ-018 The block SHALL track a two-entry pipeline of {rd, wen}: EX is the instruction issued on the last edge, and WB is the instruction issued two edges ago.
REQ-019 When WB.wen=1, the block SHALL write ans_ex to R[WB.rd] on the edge that ends the cycle in which WB is valid.
REQ-020 Forwarding: when WB.wen=1 and WB.rd matches a source being read, the block SHALL use ans_ex in place of the register-file value.
REQ-021 Hazard condition: the block SHALL detect a hazard when EX.wen=1 and EX.rd equals rd, or when B is register-sourced and EX.rd equals rs.
REQ-022 The state machine SHALL have two states, RUN and STALL.
REQ-023 In RUN with instr_valid=1 and a hazard, the block SHALL hold instr_ready=0, issue NOP (op_dec=11100, A=B=00), increment stall_cnt, and move to STALL.
REQ-024 In STALL, the block SHALL set instr_ready=1 and issue the held instr with forwarding from the now-WB entry, then return to RUN.
REQ-025 A hazard SHALL cost exactly one bubble.
REQ-026 In RUN with instr_valid=0, the block SHALL issue NOP with EX.wen=0 and SHALL NOT increment stall_cnt.
REQ-027 In RUN with no hazard, instr_ready SHALL be 1 and the block SHALL issue one instruction per cycle.
REQ-028 stall_cnt SHALL saturate at FF and SHALL NOT wrap.
REQ-029 Instruction issue latency SHALL be 1 cycle from the handshake edge to op_dec, A and B.
REQ-030 When EX and WB both target the same register, the hazard check SHALL take priority, so the newer value always wins.
REQ-031 A write to R[x] by WB and a simultaneous read of R[x] SHALL return ans_ex.

Reset
REQ-032 While reset=1 at a clock edge, the block SHALL set op_dec=11100, A=B=data_in=00, R0-R7=00, EX.wen=WB.wen=0, state=RUN, stall_cnt=00, and instr_ready=0.
REQ-033 Reset SHALL override any in-flight stall or pending writeback; a pending write is dropped.
REQ-034 instr_ready SHALL be 1 in the first cycle after reset deasserts.

Verification
REQ-035 Reset check: hold reset=1 for 2 cycles -> op_dec=11100, A=B=00, instr_ready=0, stall_cnt=00; deassert reset -> instr_ready=1.
REQ-036 Independent pair: issue ADDI R1,#05 (01000_001_00000101) then ADDI R2,#03 -> op_dec=01000, A=00, B=05, then op_dec=01000, A=00, B=03 on consecutive cycles, with no stall.
REQ-037 RAW distance 1: issue ADDI R1,#05 then ADD R2,R1 (00000_010_001_xxxxx), with bench ans_ex=05 -> one NOP bubble, instr_ready=0 for one cycle, then op_dec=00000, A=00, B=05, stall_cnt=01.
REQ-038 RAW distance 2: issue ADDI R3,#07, then 1 cycle of instr_valid=0, then ADD R4,R3 with ans_ex=07 -> no stall, B=07 via forwarding, and R3=07 afterwards.
REQ-039 Non-writing producer: issue 10111 with rd=1, then ADD R2,R1 -> no bubble, and stall_cnt is unchanged.
REQ-040 Reset mid-stall: assert reset during the STALL cycle -> state=RUN, R1 remains 00, the held instr is discarded, and op_dec=11100.
